add8_err_monitor: RTL

Hardware error-characterisation harness for 8-bit approximate adders. It sits on both sides of one adder instance. Upstream, it drives an exhaustive operand sweep of all 2^(2·WIDTH) A/B pairs into the adder. Downstream, it consumes the adder's WIDTH+1-bit sum, compares it with the exact sum, and accumulates the library's error metrics (sum of absolute error, worst-case error, error count, and optionally sum of squared error) for on-silicon or FPGA cross-checking of the published MAE/WCE/EP figures.

---
 rtl/add8_errmon_pkg.sv | 42 ++++
 rtl/add8_err_accum.sv | 91 +++++++++
 rtl/add8_err_monitor.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/add8_errmon_pkg.sv
// add8_errmon_pkg
//   Shared definitions for the approximate-adder error monitor: the sweep
//   state encoding and the width helpers. Every width is derived from the
//   operand width WIDTH.
//     ERR_W = WIDTH+1     absolute error of one pair, and worst-case error
//     CNT_W = 2*WIDTH     operand sweep counter
//     SUM_W = 3*WIDTH+1   sum of absolute errors over all pairs
//     SQ_W  = 4*WIDTH+2   sum of squared errors over all pairs
//   The functions accept any WIDTH. The localparams give the 8-bit default.
package add8_errmon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int err_w(input int w);
        return w + 1;
    endfunction

    function automatic int cnt_w(input int w);
        return 2 * w;
    endfunction

    function automatic int sum_w(input int w);
        return 3 * w + 1;
    endfunction

    function automatic int sq_w(input int w);
        return 4 * w + 2;
    endfunction

    localparam int ERR_W = err_w(DEF_WIDTH);
    localparam int CNT_W = cnt_w(DEF_WIDTH);
    localparam int SUM_W = sum_w(DEF_WIDTH);
    localparam int SQ_W  = sq_w(DEF_WIDTH);

endpackage

// File: rtl/add8_err_accum.sv
// add8_err_accum
//   This is the second pipeline stage of the error monitor. Each valid
//   absolute error e is folded into the running metrics. All outputs come
//   straight from registers.
//   Optional feature macro: ADD8_ERRMON_MSE_EN. When it is defined, the module
//   adds the e*e product and the sq_err_sum accumulator.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     clear        zeroes every accumulator (start of a new sweep)
//     valid, e     one absolute error sample from stage 1
//     err_sum      sum of e
//     wce          maximum e
//     err_count    number of samples with e != 0
//     sq_err_sum   sum of e*e (present only when ADD8_ERRMON_MSE_EN is defined)
module add8_err_accum
    import add8_errmon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      valid,
    input  logic [err_w(WIDTH)-1:0]   e,
    output logic [sum_w(WIDTH)-1:0]   err_sum,
    output logic [err_w(WIDTH)-1:0]   wce,
    output logic [2*WIDTH:0]          err_count
`ifdef ADD8_ERRMON_MSE_EN
    ,
    output logic [sq_w(WIDTH)-1:0]    sq_err_sum
`endif
);

    localparam int EW = err_w(WIDTH);
    localparam int SW = sum_w(WIDTH);
    localparam int NW = 2 * WIDTH + 1;

    logic [SW-1:0] err_sum_r;
    logic [EW-1:0] wce_r;
    logic [NW-1:0] err_count_r;
    logic [NW-1:0] nz_s;

    assign nz_s      = {{(NW-1){1'b0}}, (e != {EW{1'b0}})};
    assign err_sum   = err_sum_r;
    assign wce       = wce_r;
    assign err_count = err_count_r;

    // Accumulate the core metrics. Sizing guarantees that none of them can wrap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_sum_r   <= {SW{1'b0}};
            wce_r       <= {EW{1'b0}};
            err_count_r <= {NW{1'b0}};
        end else if (valid) begin
            err_sum_r   <= err_sum_r + SW'(e);
            err_count_r <= err_count_r + nz_s;
            if (e > wce_r) begin
                wce_r <= e;
            end else begin
                wce_r <= wce_r;
            end
        end else begin
            err_sum_r   <= err_sum_r;
            wce_r       <= wce_r;
            err_count_r <= err_count_r;
        end
    end

`ifdef ADD8_ERRMON_MSE_EN
    localparam int PW = 2 * EW;
    localparam int QW = sq_w(WIDTH);

    logic [PW-1:0] sq_s;
    logic [QW-1:0] sq_err_sum_r;

    assign sq_s       = PW'(e) * PW'(e);
    assign sq_err_sum = sq_err_sum_r;

    // Accumulate the squared error alongside the core metrics.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sq_err_sum_r <= {QW{1'b0}};
        end else if (valid) begin
            sq_err_sum_r <= sq_err_sum_r + QW'(sq_s);
        end else begin
            sq_err_sum_r <= sq_err_sum_r;
        end
    end
`endif

endmodule

// File: rtl/add8_err_monitor.sv
// add8_err_monitor
//   This is the error-characterisation harness for one approximate adder. It
//   drives an exhaustive sweep of all 2^(2*WIDTH) operand pairs into the adder
//   and compares each combinational result with the exact sum. The resulting
//   errors are accumulated in add8_err_accum.
//   Optional feature macro: ADD8_ERRMON_MSE_EN. When it is defined, the
//   sq_err_sum output is present.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     start         begins a sweep (accepted in IDLE or DONE only)
//     op_a, op_b    operands to the adder (registered, counter low/high half)
//     approx_sum    adder output, combinational in op_a/op_b
//     busy          high in SWEEP and DRAIN
//     done          high in DONE, until the next start or rst
//     err_sum, wce, err_count, sq_err_sum   accumulated error metrics
module add8_err_monitor
    import add8_errmon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [WIDTH-1:0]          op_a,
    output logic [WIDTH-1:0]          op_b,
    input  logic [WIDTH:0]            approx_sum,
    output logic                      busy,
    output logic                      done,
    output logic [sum_w(WIDTH)-1:0]   err_sum,
    output logic [WIDTH:0]            wce,
    output logic [2*WIDTH:0]          err_count
`ifdef ADD8_ERRMON_MSE_EN
    ,
    output logic [sq_w(WIDTH)-1:0]    sq_err_sum
`endif
);

    localparam int EW = err_w(WIDTH);
    localparam int CW = cnt_w(WIDTH);

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic          done_r;
    logic          v1_r;
    logic [EW-1:0] e_r;
    logic [EW-1:0] exact_s;
    logic [EW-1:0] e_s;
    logic          clear_s;

    // The operands are the two halves of the registered sweep counter. After
    // the counter wraps, they rest at zero outside SWEEP.
    assign op_a = cnt_r[WIDTH-1:0];
    assign op_b = cnt_r[CW-1:WIDTH];
    assign busy = busy_r;
    assign done = done_r;

    // Accept a start request only while the monitor is not sweeping.
    always_comb begin
        case (state_r)
            IDLE, DONE: clear_s = start;
            default:    clear_s = 1'b0;
        endcase
    end

    // Stage 1 combinational part: compute the absolute distance from the exact sum, with no wrap.
    always_comb begin
        exact_s = EW'(op_a) + EW'(op_b);
        if (approx_sum >= exact_s) begin
            e_s = approx_sum - exact_s;
        end else begin
            e_s = exact_s - approx_sum;
        end
    end

    // Sweep FSM with the counter and the registered busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r <= SWEEP;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= state_r;
                        cnt_r   <= cnt_r;
                        busy_r  <= busy_r;
                        done_r  <= done_r;
                    end
                end
                SWEEP: begin
                    // The wrap to zero on the last pair coincides with the
                    // exit, so no pair is repeated.
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (&cnt_r) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= SWEEP;
                    end
                end
                DRAIN: begin
                    state_r <= DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CW{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1 register: one error sample for every SWEEP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            e_r  <= {EW{1'b0}};
        end else begin
            v1_r <= (state_r == SWEEP);
            e_r  <= e_s;
        end
    end

    add8_err_accum #(
        .WIDTH      (WIDTH)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_s),
        .valid      (v1_r),
        .e          (e_r),
        .err_sum    (err_sum),
        .wce        (wce),
        .err_count  (err_count)
`ifdef ADD8_ERRMON_MSE_EN
        ,
        .sq_err_sum (sq_err_sum)
`endif
    );

endmodule
